bram_vec_adder: RTL and testbench
=================================

Name: bram_vec_adder

Overview:
- Parametrised successor to the single registered 16-bit adder: streams two operand vectors out of two BRAM read ports, adds element-wise through a registered pipeline, and writes results into a third BRAM write port.
- Start/busy/done handshake with a programmable source base, destination base and length.
- Tolerates BRAM read latency of 1 or 2 cycles.
- Sits between the operand BRAMs and the result BRAM in the BRAM-adder datapath, under control of the test/host sequencer.

Parameters:
- DATA_W, 16: operand and result width in bits.
- ADDR_W, 10: BRAM address width; depth = 2**ADDR_W.
- RD_LAT, 1: BRAM read latency in cycles (legal values 1 or 2).

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin; sampled only in IDLE.
- src_base  in  ADDR_W  first read address (both operand BRAMs).
- dst_base  in  ADDR_W  first write address (result BRAM).
- len  in  ADDR_W+1  element count, 0..2**ADDR_W.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  read enable to both operand BRAMs.
- rd_addr  out  ADDR_W  shared read address.
- douta11  in  DATA_W  operand A read data.
- douta22  in  DATA_W  operand B read data.
- wr_en  out  1  result BRAM write enable.
- wr_addr  out  ADDR_W  result write address.
- wr_data  out  DATA_W  result write data.
- ovf_cnt  out  ADDR_W+1  count of elements whose add carried out (or clipped) during the last run.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - busy, done, rd_en, wr_en = 0.
  - rd_addr, wr_addr, wr_data, ovf_cnt = 0.
  - Pipeline valid bits cleared.
  - Reset mid-run aborts immediately, with no further writes and no done.
- FSM states:
  - IDLE: start=1 latches src_base, dst_base and len.
    - len=0: go to DONE; no rd_en and no wr_en ever asserted.
    - len>0: go to READ, set busy=1, clear ovf_cnt.
  - READ: rd_en=1 each cycle. rd_addr = src_base+i for i = 0..len-1, wrapping modulo 2**ADDR_W. After the issue with i = len-1, go to DRAIN.
  - DRAIN: rd_en=0. Wait until the pipeline valid bits are empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored; no queuing.
- Pipeline:
  - A valid shift register of depth RD_LAT tracks issued reads.
  - When data is valid, the sum is registered: wr_data <= douta11 + douta22, truncated to DATA_W.
  - wr_en=1 and wr_addr = dst_base+j (wrapping) in the same cycle.
  - Latency from rd_en to the matching wr_en is RD_LAT+1 cycles; throughput is one element per cycle.
- Overflow: the carry out of bit DATA_W-1 increments ovf_cnt; it saturates at 2**ADDR_W. ovf_cnt holds its value after done until the next accepted start.
- Timing with len=N: done asserts N+RD_LAT+2 cycles after the start cycle.
- wr_data and wr_addr hold their last values when wr_en=0.
- Overlapping source and destination ranges are permitted; results follow BRAM read-before-write semantics, and the block adds no hazard logic.

Optional Feature:
- Macro: BRAM_VEC_ADDER_SAT_EN.
- Defined: unsigned saturating add. On carry out, wr_data = all ones, and ovf_cnt still increments.
- Undefined: wrap-around modulo 2**DATA_W, as above.
- Port list identical in both builds.

Test Plan:
- A[0..3] = 1,2,3,4 and B = 10,20,30,40; start with src_base=0, dst_base=100, len=4, RD_LAT=1 -> four consecutive wr_en at addresses 100..103 with data 11,22,33,44, done 7 cycles after start, ovf_cnt=0.
- A = 16'hFFFF, B = 16'h0002, len=1 -> without SAT_EN wr_data=16'h0001; with SAT_EN wr_data=16'hFFFF; ovf_cnt=1 in both builds.
- src_base=1022, dst_base=1023, len=3, ADDR_W=10 -> rd_addr 1022,1023,0 and wr_addr 1023,0,1.
- len=0 -> done pulses, rd_en and wr_en never assert, busy only as spec'd.
- RD_LAT=2, len=5 -> wr_en lags rd_en by 3 cycles and done arrives 9 cycles after start; a second start pulsed while busy is ignored.
- rst_n low for 1 cycle mid-READ of len=8 -> all outputs 0 immediately, no done, and a new start afterwards completes normally.

Source files
------------

// File: rtl/bram_vec_adder.sv
// -----------------------------------------------------------------------------
// bram_vec_adder
//
// Streams two operand vectors out of a pair of BRAM read ports (sharing one
// address), adds them element-wise through a registered stage and writes the
// results into a third BRAM through its write port. A start/busy/done
// handshake carries a programmable source base, destination base and length.
//
// Build option:
//   BRAM_VEC_ADDER_SAT_EN  defined   -> unsigned saturating add (all ones on
//                                       carry out)
//                          undefined -> wrap-around add modulo 2**DATA_W
//
// Parameters:
//   DATA_W  operand/result width
//   ADDR_W  BRAM address width (depth 2**ADDR_W)
//   RD_LAT  BRAM read latency in cycles, 1 or 2
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start              one-cycle request, sampled only while idle
//   src_base/dst_base  first read / first write address
//   len                element count, 0..2**ADDR_W
//   busy               high from the accepted start until done
//   done               one-cycle pulse after the last write
//   rd_en/rd_addr      read request to both operand BRAMs
//   douta11/douta22    operand A / operand B read data
//   wr_en/wr_addr/wr_data  result BRAM write port
//   ovf_cnt            elements whose add carried out during the last run
// -----------------------------------------------------------------------------
module bram_vec_adder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] douta11,
  input  logic [DATA_W-1:0] douta22,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   ovf_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0]   ONE_L   = 1;
  localparam logic [ADDR_W-1:0] ONE_A   = 1;
  localparam logic [ADDR_W:0]   OVF_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                start_acc;

  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic                vld_out;

  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                wr_en_q;
  logic [ADDR_W:0]     ovf_cnt_q;

  logic [DATA_W:0]     sum_full;
  logic                carry;
  logic [DATA_W-1:0]   sum_res;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    start_acc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          len_d     = len;
          cnt_d     = '0;
          rd_addr_d = src_base;
          state_d   = (len == '0) ? S_DONE : S_READ;
        end
      end

      S_READ: begin
        // rd_addr holds the last issued address once the final read goes out.
        if (cnt_q + ONE_L == len_q) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d     = cnt_q + ONE_L;
          rd_addr_d = rd_addr_q + ONE_A;  // wraps modulo 2**ADDR_W
        end
      end

      // Once the read-valid pipe is empty the final sum is already registered,
      // so done lands in the cycle right after the last write.
      S_DRAIN: begin
        if (vld_q == '0) state_d = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign rd_en   = (state_q == S_READ);
  assign rd_addr = rd_addr_q;
  assign busy    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Read-valid pipe: one bit per cycle of BRAM latency, so vld_out lines up
  // with the read data belonging to an issued rd_en.
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  assign vld_out = vld_q[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Adder and write stage
  // ---------------------------------------------------------------------------
  assign sum_full = {1'b0, douta11} + {1'b0, douta22};
  assign carry    = sum_full[DATA_W];

`ifdef BRAM_VEC_ADDER_SAT_EN
  assign sum_res = carry ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
  assign sum_res = sum_full[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_ptr_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      vld_q   <= vld_d;
      wr_en_q <= vld_out;

      // The pipe is always empty while idle, so a start never coincides with
      // a write below.
      if (start_acc) begin
        wr_ptr_q  <= dst_base;
        ovf_cnt_q <= '0;
      end

      // Address and data only move on a write; otherwise they hold.
      if (vld_out) begin
        wr_data_q <= sum_res;
        wr_addr_q <= wr_ptr_q;
        wr_ptr_q  <= wr_ptr_q + ONE_A;
        if (carry && (ovf_cnt_q != OVF_MAX)) begin
          ovf_cnt_q <= ovf_cnt_q + ONE_L;
        end
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_bram_vec_adder.sv
// -----------------------------------------------------------------------------
// tb_bram_vec_adder
//
// Two instances share clock and reset: index 0 with RD_LAT=1, index 1 with
// RD_LAT=2. Each has its own operand memories behind a behavioural BRAM read
// model. Expected reads and writes are pushed to scoreboard queues when a job
// is issued; a negedge monitor pops and compares them as the DUTs produce
// rd_en / wr_en.
// -----------------------------------------------------------------------------
module tb_bram_vec_adder;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start    [2];
  logic [AW-1:0] src_base [2];
  logic [AW-1:0] dst_base [2];
  logic [AW:0]   len      [2];
  logic          busy     [2];
  logic          done     [2];
  logic          rd_en    [2];
  logic [AW-1:0] rd_addr  [2];
  logic [DW-1:0] douta11  [2];
  logic [DW-1:0] douta22  [2];
  logic          wr_en    [2];
  logic [AW-1:0] wr_addr  [2];
  logic [DW-1:0] wr_data  [2];
  logic [AW:0]   ovf_cnt  [2];

  bram_vec_adder #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .src_base(src_base[0]), .dst_base(dst_base[0]), .len(len[0]),
    .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .douta11(douta11[0]), .douta22(douta22[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .ovf_cnt(ovf_cnt[0])
  );

  bram_vec_adder #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .src_base(src_base[1]), .dst_base(dst_base[1]), .len(len[1]),
    .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .douta11(douta11[1]), .douta22(douta22[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .ovf_cnt(ovf_cnt[1])
  );

  // Operand memories and BRAM read models (latency 1 and 2).
  logic [DW-1:0] mem_a [2][DEPTH];
  logic [DW-1:0] mem_b [2][DEPTH];
  logic [DW-1:0] a_s1, b_s1;

  always @(posedge clk) begin
    if (rd_en[0]) begin
      douta11[0] <= mem_a[0][rd_addr[0]];
      douta22[0] <= mem_b[0][rd_addr[0]];
    end
    if (rd_en[1]) begin
      a_s1 <= mem_a[1][rd_addr[1]];
      b_s1 <= mem_b[1][rd_addr[1]];
    end
    douta11[1] <= a_s1;
    douta22[1] <= b_s1;
  end

  // Scoreboard.
  typedef struct {
    int            inst;
    logic [AW-1:0] addr;
  } rd_exp_t;

  typedef struct {
    int            inst;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_seen   [2] = '{0, 0};
  int wr_seen   [2] = '{0, 0};
  int done_seen [2] = '{0, 0};
  int first_rd  [2] = '{-1, -1};
  int first_wr  [2] = '{-1, -1};
  int last_wr   [2] = '{-1, -1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: compares every read issue and every write against the queues.
  always @(negedge clk) begin : monitor
    rd_exp_t r;
    wr_exp_t w;
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k] === 1'b1) begin
        rd_seen[k]++;
        if (first_rd[k] < 0) first_rd[k] = cyc;
        if (rd_q.size() == 0) begin
          check($sformatf("rd_unexpected_u%0d", k), 32'd1, 32'd0);
        end else begin
          r = rd_q.pop_front();
          check($sformatf("rd_inst_u%0d", k), k, r.inst);
          check($sformatf("rd_addr_u%0d", k), rd_addr[k], r.addr);
        end
      end
      if (wr_en[k] === 1'b1) begin
        wr_seen[k]++;
        if (first_wr[k] < 0) first_wr[k] = cyc;
        last_wr[k] = cyc;
        if (wr_q.size() == 0) begin
          check($sformatf("wr_unexpected_u%0d", k), 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check($sformatf("wr_inst_u%0d", k), k, w.inst);
          check($sformatf("wr_addr_u%0d", k), wr_addr[k], w.addr);
          check($sformatf("wr_data_u%0d", k), wr_data[k], w.data);
        end
      end
      if (done[k] === 1'b1) done_seen[k]++;
    end
  end

  // Push the expected reads/writes of one job; returns its overflow count.
  task automatic push_job(input int k, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int n, output int exp_ovf);
    exp_ovf = 0;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] ra;
      logic [AW-1:0] wa;
      logic [DW:0]   full;
      logic [DW-1:0] data;
      ra   = src + AW'(i);
      wa   = dst + AW'(i);
      full = {1'b0, mem_a[k][ra]} + {1'b0, mem_b[k][ra]};
      data = full[DW-1:0];
      if (full[DW]) begin
        exp_ovf++;
`ifdef BRAM_VEC_ADDER_SAT_EN
        data = '1;
`endif
      end
      rd_q.push_back('{k, ra});
      wr_q.push_back('{k, wa, data});
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_busy"},    busy[k],    0);
    check({tag, "_done"},    done[k],    0);
    check({tag, "_rd_en"},   rd_en[k],   0);
    check({tag, "_wr_en"},   wr_en[k],   0);
    check({tag, "_rd_addr"}, rd_addr[k], 0);
    check({tag, "_wr_addr"}, wr_addr[k], 0);
    check({tag, "_wr_data"}, wr_data[k], 0);
    check({tag, "_ovf_cnt"}, ovf_cnt[k], 0);
  endtask

  // Run one job to completion. poke pulses a second start while busy.
  task automatic run(input int k, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                     input int n, input bit poke, input string tag);
    int c0, lat, exp_ovf, rd0, wr0, rdl;
    rdl = k + 1;
    push_job(k, src, dst, n, exp_ovf);
    rd0 = rd_seen[k];
    wr0 = wr_seen[k];
    first_rd[k] = -1;
    first_wr[k] = -1;
    @(posedge clk); #1;
    start[k] = 1'b1; src_base[k] = src; dst_base[k] = dst; len[k] = (AW+1)'(n);
    c0 = cyc;
    @(posedge clk); #1;
    start[k] = 1'b0;
    check({tag, "_busy_after_start"}, busy[k], (n > 0) ? 1 : 0);
    lat = -1;
    for (int t = 0; t < 200; t++) begin
      if (done[k] === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      if (poke && t == 2) begin
        start[k] = 1'b1; src_base[k] = 10'd300; dst_base[k] = 10'd400; len[k] = 11'd2;
      end else if (poke && t == 3) begin
        start[k] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
    check({tag, "_done_latency"}, lat, (n == 0) ? 1 : n + rdl + 2);
    check({tag, "_busy_at_done"}, busy[k], 0);
    check({tag, "_rd_count"}, rd_seen[k] - rd0, n);
    check({tag, "_wr_count"}, wr_seen[k] - wr0, n);
    check({tag, "_ovf_cnt"}, ovf_cnt[k], exp_ovf);
    if (n > 0) begin
      check({tag, "_rd_to_wr"}, first_wr[k] - first_rd[k], rdl + 1);
      check({tag, "_wr_burst"}, last_wr[k] - first_wr[k], n - 1);
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done[k], 0);
    check({tag, "_ovf_hold"}, ovf_cnt[k], exp_ovf);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_wr_left"}, wr_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int ov_dummy;
    int wr_snap, done_snap;

    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; src_base[k] = '0; dst_base[k] = '0; len[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[k][i] = DW'($urandom);
        mem_b[k][i] = DW'($urandom);
      end
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "rst_u0");
    check_idle(1, "rst_u1");
    rst_n = 1'b1;

    // Basic 4-element vector, RD_LAT=1.
    for (int i = 0; i < 4; i++) begin
      mem_a[0][i] = DW'(i + 1);
      mem_b[0][i] = DW'(10 * (i + 1));
    end
    run(0, 10'd0, 10'd100, 4, 1'b0, "basic");
    check("basic_last_data", wr_data[0], 44);
    check("basic_last_addr", wr_addr[0], 103);

    // Carry out on a single element.
    mem_a[0][5] = 16'hFFFF;
    mem_b[0][5] = 16'h0002;
    run(0, 10'd5, 10'd200, 1, 1'b0, "ovf");
`ifdef BRAM_VEC_ADDER_SAT_EN
    check("ovf_wr_data", wr_data[0], 32'h0000FFFF);
`else
    check("ovf_wr_data", wr_data[0], 32'h00000001);
`endif
    check("ovf_count_one", ovf_cnt[0], 1);

    // Address wrap on both read and write sides.
    run(0, 10'd1022, 10'd1023, 3, 1'b0, "wrap");
    check("wrap_last_wr_addr", wr_addr[0], 1);
    check("wrap_last_rd_addr", rd_addr[0], 0);

    // Zero length: done only, no traffic.
    run(0, 10'd7, 10'd9, 0, 1'b0, "len0");

    // RD_LAT=2 with a second start pulsed while busy.
    run(1, 10'd10, 10'd20, 5, 1'b1, "lat2");

    // Reset in the middle of READ aborts the job.
    push_job(0, 10'd30, 10'd40, 8, ov_dummy);
    @(posedge clk); #1;
    start[0] = 1'b1; src_base[0] = 10'd30; dst_base[0] = 10'd40; len[0] = 11'd8;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_read", rd_en[0], 1);
    done_snap = done_seen[0];
    rst_n = 1'b0;
    #1;
    check_idle(0, "abort");
    rd_q.delete();
    wr_q.delete();
    wr_snap = wr_seen[0];
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", done_seen[0] - done_snap, 0);
    check("abort_no_write", wr_seen[0] - wr_snap, 0);

    // A fresh job after the abort completes normally.
    run(0, 10'd50, 10'd60, 6, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
